// File: rtl/decimal_entry_pkg.sv
// ---------------------------------------------------------------------------
// decimal_entry_pkg
// Shared definitions for the decimal keypad entry front end.
//   - Keypad control codes. Codes 0x0-0x9 are digits. 0xE and 0xF are reserved.
//   - FSM state encoding for the entry controller.
//   - Saturation ceiling for the integer part.
// ---------------------------------------------------------------------------
package decimal_entry_pkg;

    localparam logic [3:0] KEY_POINT = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_NEG   = 4'hD;

    localparam int INT_MAX = 255;

    typedef enum logic [1:0] {
        INT  = 2'd0,
        FRAC = 2'd1,
        DONE = 2'd2
    } entry_state_t;

endpackage

// File: rtl/dec_accum_sat.sv
// ---------------------------------------------------------------------------
// dec_accum_sat
// Combinational decimal shift-in with saturation. It computes acc*10 + digit
// at 12 bits and clamps the result to INT_MAX.
// Ports:
//   acc      in  [7:0]  current integer accumulator
//   digit    in  [3:0]  decimal digit being appended (0..9)
//   next_acc out [7:0]  min(acc*10 + digit, INT_MAX)
//   sat      out        high when the unclamped result exceeded INT_MAX
// ---------------------------------------------------------------------------
module dec_accum_sat
    import decimal_entry_pkg::*;
(
    input  logic [7:0] acc,
    input  logic [3:0] digit,
    output logic [7:0] next_acc,
    output logic       sat
);

    logic [11:0] wide;

    // The worst case is 255*10 + 15 = 2565, so 12 bits hold the result without wrap.
    // The clamp is then a simple compare against the ceiling.
    always_comb begin
        wide     = 12'(acc) * 12'd10 + 12'(digit);
        sat      = (wide > 12'(INT_MAX));
        next_acc = sat ? 8'(INT_MAX) : wide[7:0];
    end

endmodule

// File: rtl/decimal_key_entry.sv
// ---------------------------------------------------------------------------
// decimal_key_entry
// Builds a signed decimal operand (integer 0..255 plus one tenths digit) from
// keypad codes. It hands the result to the float converter over valid/ready.
// Ports:
//   clk        in         system clock, rising edge
//   reset      in         synchronous active-high reset
//   key_valid  in         key_code is valid this cycle
//   key_code   in  [3:0]  digit 0-9, A point, B enter, C clear, D negate
//   key_ready  out        block accepts a key (INT or FRAC state)
//   out_valid  out        A/B/neg/ovf hold a completed operand
//   out_ready  in         consumer takes the operand
//   A          out [7:0]  integer part
//   B          out [7:0]  tenths digit, 0..9
//   neg        out        sign requested by the user
//   ovf        out        integer saturated or digits dropped
// ---------------------------------------------------------------------------
module decimal_key_entry
    import decimal_entry_pkg::*;
#(
    parameter int MAX_INT_DIGITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       neg,
    output logic       ovf
);

    localparam int CNT_W = $clog2(MAX_INT_DIGITS + 1);

    entry_state_t     state;
    logic [7:0]       acc;
    logic [3:0]       frac;
    logic [CNT_W-1:0] count;
    logic             frac_seen;
    logic             entry_neg;
    logic             entry_ovf;

    logic [7:0]       next_acc;
    logic             acc_sat;
    logic             key_accept;
    logic             is_digit;

    dec_accum_sat u_accum (
        .acc      (acc),
        .digit    (key_code),
        .next_acc (next_acc),
        .sat      (acc_sat)
    );

    // key_ready is derived from the state register only.
    // This keeps any combinational path from key_valid or out_ready away from the outputs.
    always_comb begin
        key_ready  = (state != DONE);
        key_accept = key_valid & key_ready;
        is_digit   = (key_code <= 4'd9);
    end

    // Entry controller. The working registers (acc, frac, count, entry_neg,
    // entry_ovf) collect the operand as keys arrive. A/B/neg/ovf are copied
    // from them only on enter, so the presented result stays stable through
    // DONE and also after the handshake, until the next enter. Reset is
    // checked first so that it overrides any key or handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INT;
            acc       <= '0;
            frac      <= '0;
            count     <= '0;
            frac_seen <= 1'b0;
            entry_neg <= 1'b0;
            entry_ovf <= 1'b0;
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                INT, FRAC: begin
                    if (key_accept) begin
                        if (is_digit) begin
                            if (state == INT) begin
                                // A full digit count drops the new digit.
                                // A zero typed while acc is still zero is a
                                // leading zero and does not use up a digit position.
                                if (count == CNT_W'(MAX_INT_DIGITS)) begin
                                    entry_ovf <= 1'b1;
                                end else if (!(key_code == 4'd0 && acc == 8'd0)) begin
                                    acc   <= next_acc;
                                    count <= count + CNT_W'(1);
                                    if (acc_sat) begin
                                        entry_ovf <= 1'b1;
                                    end
                                end
                            end else if (!frac_seen) begin
                                frac      <= key_code;
                                frac_seen <= 1'b1;
                            end
                        end else begin
                            case (key_code)
                                KEY_POINT: begin
                                    if (state == INT) begin
                                        state <= FRAC;
                                    end
                                end
                                KEY_ENTER: begin
                                    A         <= acc;
                                    B         <= {4'b0000, frac};
                                    neg       <= entry_neg;
                                    ovf       <= entry_ovf;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end
                                KEY_CLEAR: begin
                                    acc       <= '0;
                                    frac      <= '0;
                                    count     <= '0;
                                    frac_seen <= 1'b0;
                                    entry_neg <= 1'b0;
                                    entry_ovf <= 1'b0;
                                    state     <= INT;
                                end
                                KEY_NEG: begin
                                    entry_neg <= ~entry_neg;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= INT;
                        acc       <= '0;
                        frac      <= '0;
                        count     <= '0;
                        frac_seen <= 1'b0;
                        entry_neg <= 1'b0;
                        entry_ovf <= 1'b0;
                    end
                end
                default: begin
                    state <= INT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_key_entry.sv
// ---------------------------------------------------------------------------
// tb_decimal_key_entry
// Directed key sequences go to decimal_key_entry. The expected operands are
// computed by hand and pushed into a scoreboard when each sequence is issued.
// A monitor pops an entry on every accepted output handshake and compares it.
// Inputs change 1 ns after the rising edge. The monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_decimal_key_entry;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       neg;
    logic       ovf;

    exp_t sb[$];
    exp_t monExp;
    int   vectors    = 0;
    int   miscompares = 0;
    int   pulses     = 0;

    decimal_key_entry #(.MAX_INT_DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .neg       (neg),
        .ovf       (ovf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(input int a, input int b, input bit n, input bit o);
        exp_t e;
        e.a   = 8'(a);
        e.b   = 8'(b);
        e.neg = n;
        e.ovf = o;
        return e;
    endfunction

    // One comparison. Every mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one key. It waits (bounded) for key_ready, then holds key_valid for one edge.
    task automatic sendKey(input logic [3:0] k);
        int w = 0;
        while (!key_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!key_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL key_ready_timeout: got 0, expected 1");
        end
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Issues a whole key sequence written as hex characters and records the expected operand.
    task automatic applyStimulus(input string seq, input exp_t e);
        byte        c;
        logic [3:0] k;
        sb.push_back(e);
        for (int i = 0; i < seq.len(); i++) begin
            c = seq[i];
            if (c >= "0" && c <= "9") k = 4'(c - "0");
            else                      k = 4'(c - "A" + 10);
            sendKey(k);
        end
    endtask

    // Waits (bounded) until the monitor has consumed every expected operand.
    task automatic waitDrain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    // Monitor: compares each operand at the edge that will accept it. A
    // handshake that coincides with reset is discarded by the DUT, so it is skipped here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            pulses++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_operand: got A=%0d B=%0d, expected none", A, B);
            end else begin
                monExp = sb.pop_front();
                checkOutput("mon_A",   A,           monExp.a);
                checkOutput("mon_B",   B,           monExp.b);
                checkOutput("mon_neg", 8'(neg),     8'(monExp.neg));
                checkOutput("mon_ovf", 8'(ovf),     8'(monExp.ovf));
            end
        end
    end

    // Main directed sequence.
    initial begin
        int pulseBase;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_key_ready", 8'(key_ready), 8'd1);
        checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_A",         A,             8'd0);
        checkOutput("rst_B",         B,             8'd0);
        checkOutput("rst_neg",       8'(neg),       8'd0);
        checkOutput("rst_ovf",       8'(ovf),       8'd0);

        // Basic operand with backpressure held for five cycles.
        applyStimulus("12A5B", mkExp(12, 5, 0, 0));
        checkOutput("lat_out_valid", 8'(out_valid), 8'd1);
        checkOutput("done_key_ready", 8'(key_ready), 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 8'(out_valid), 8'd1);
            checkOutput("hold_A",         A,             8'd12);
            checkOutput("hold_B",         B,             8'd5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_out_valid", 8'(out_valid), 8'd0);
        checkOutput("post_key_ready", 8'(key_ready), 8'd1);
        checkOutput("post_A_kept",    A,             8'd12);
        waitDrain();

        // Saturation, leading zeros, dropped digits, fraction truncation, sign, clear.
        applyStimulus("300B",   mkExp(255, 0, 0, 1));
        applyStimulus("007B",   mkExp(7,   0, 0, 0));
        applyStimulus("1234B",  mkExp(123, 0, 0, 1));
        applyStimulus("A78A9B", mkExp(0,   7, 0, 0));
        applyStimulus("D4DDB",  mkExp(4,   0, 1, 0));
        applyStimulus("9C2A3B", mkExp(2,   3, 0, 0));
        waitDrain();

        // key_valid stays high through DONE. No extra key should be taken.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        sb.push_back(mkExp(5, 0, 0, 0));
        sendKey(4'h5);
        key_valid = 1'b1;
        key_code  = 4'hB;
        @(posedge clk);
        #1;
        key_code = 4'h7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("held_key_ready", 8'(key_ready), 8'd0);
            checkOutput("held_A",         A,             8'd5);
        end
        key_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        // Reset while an operand is pending, with a key and the handshake in the same cycle.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        sendKey(4'hD);
        sendKey(4'h3);
        sendKey(4'h0);
        sendKey(4'h0);
        sendKey(4'hB);
        checkOutput("pre_rst_A", A, 8'd255);
        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h3;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        key_valid = 1'b0;
        checkOutput("rst2_out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst2_key_ready", 8'(key_ready), 8'd1);
        checkOutput("rst2_A",         A,             8'd0);
        checkOutput("rst2_neg",       8'(neg),       8'd0);
        checkOutput("rst2_ovf",       8'(ovf),       8'd0);
        applyStimulus("1B", mkExp(1, 0, 0, 0));
        waitDrain();

        // Back-to-back operands with the consumer always ready.
        pulseBase = pulses;
        applyStimulus("4B",   mkExp(4, 0, 0, 0));
        applyStimulus("6A1B", mkExp(6, 1, 0, 0));
        waitDrain();
        checkOutput("b2b_pulses", 8'(pulses - pulseBase), 8'd2);

        checkOutput("sb_empty", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
